// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand loader: default geometry, loader
// state encoding, and the row-major slot-index helper.
// Latency: n/a (package). Backpressure: n/a (package).
package matrix_pkg;

  // Default geometry: A is N x M, B is M x N, elements are W bits wide.
  localparam int N_DEF = 4;
  localparam int M_DEF = 2;
  localparam int W_DEF = 32;

  // Loader states, in frame order.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Row-major slot index of element (r, c) in a matrix with 'cols' columns.
  function automatic int idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/mat_slot_counter.sv
// Wrap counter that walks the element slots of one matrix.
// Latency: count updates on the edge after inc/clr; at_term is combinational.
// Backpressure: none; advances only when the owner pulses inc.
//
// Ports:
//   clk, reset      clock, async active-high reset (count -> 0)
//   clr             synchronous return to 0, wins over inc
//   inc             advance; wraps to 0 when count == term
//   term            terminal value for the current matrix
//   count           current slot index
//   at_term         count == term
module mat_slot_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             at_term
);

  assign at_term = (count == term);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= at_term ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Packs a serial word stream into A (N x M) then B (M x N), row-major, and
// presents both as one operand set. Latency: out_valid rises 1 cycle after the
// final B word. Backpressure: in_ready drops for the whole HOLD phase until
// the consumer asserts out_ready.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   clear                 synchronous flush (same effect as reset)
//   in_data/valid/ready   input word stream; in_last tags the final B word
//   a_out                 A packed, a[i][j] at [(i*M+j)*W +: W]
//   b_out                 B packed, b[e][f] at [(e*N+f)*W +: W]
//   out_valid/out_ready   operand-set handshake
//   frame_err             sticky: misplaced or missing in_last seen
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int W = W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic [N*M*W-1:0] a_out,
  output logic [M*N*W-1:0] b_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err
);

  localparam int SLOTS = N * M;
  localparam int IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int BW    = $clog2(SLOTS * W);

  // A and B hold the same element count, so both load states share a
  // terminal value; the mux keeps the per-state selection explicit.
  localparam logic [IW-1:0] TERM_A = IW'(N * M - 1);
  localparam logic [IW-1:0] TERM_B = IW'(M * N - 1);

  state_t            state_q, state_d;
  logic [SLOTS*W-1:0] a_q, b_q;
  logic              out_valid_q;
  logic              frame_err_q;

  logic [IW-1:0]     slot_idx;
  logic [IW-1:0]     slot_term;
  logic              slot_at_term;
  logic [BW-1:0]     bit_base;

  logic              accept;
  logic              cnt_inc, cnt_clr;
  logic              a_we, b_we;
  logic              bus_zero;
  logic              set_err, set_valid, clr_valid;

  assign in_ready  = (state_q != HOLD);
  // clear takes priority over any word presented in the same cycle.
  assign accept    = in_valid && in_ready && !clear;
  assign slot_term = (state_q == LOAD_B) ? TERM_B : TERM_A;
  assign bit_base  = BW'(slot_idx * W);

  mat_slot_counter #(
    .WIDTH (IW)
  ) u_slot_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .term    (slot_term),
    .count   (slot_idx),
    .at_term (slot_at_term)
  );

  always_comb begin
    state_d   = state_q;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    a_we      = 1'b0;
    b_we      = 1'b0;
    bus_zero  = 1'b0;
    set_err   = 1'b0;
    set_valid = 1'b0;
    clr_valid = 1'b0;

    if (clear) begin
      state_d   = LOAD_A;
      cnt_clr   = 1'b1;
      bus_zero  = 1'b1;
      clr_valid = 1'b1;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (accept) begin
            if (in_last) begin
              // in_last can never be legal while loading A: drop and restart.
              state_d  = LOAD_A;
              cnt_clr  = 1'b1;
              bus_zero = 1'b1;
              set_err  = 1'b1;
            end else begin
              a_we    = 1'b1;
              cnt_inc = 1'b1;
              if (slot_at_term) state_d = LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (in_last && !slot_at_term) begin
              state_d  = LOAD_A;
              cnt_clr  = 1'b1;
              bus_zero = 1'b1;
              set_err  = 1'b1;
            end else begin
              b_we    = 1'b1;
              cnt_inc = 1'b1;
              if (slot_at_term) begin
                // A missing in_last is flagged but the frame still completes.
                state_d   = HOLD;
                set_valid = 1'b1;
                if (!in_last) set_err = 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d   = LOAD_A;
            cnt_clr   = 1'b1;
            clr_valid = 1'b1;
          end
        end
        default: begin
          state_d = LOAD_A;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;

      // Buses are not wiped between good frames; slots are overwritten in place.
      if (bus_zero) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        if (a_we) a_q[bit_base +: W] <= in_data;
        if (b_we) b_q[bit_base +: W] <= in_data;
      end

      if (clear)        frame_err_q <= 1'b0;
      else if (set_err) frame_err_q <= 1'b1;

      if (clr_valid)      out_valid_q <= 1'b0;
      else if (set_valid) out_valid_q <= 1'b1;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule
